// File: rtl/sr_latch_driver_if.sv
// Request handshake bundle between the control logic and the SR latch sequencer.
`timescale 1ns/1ps
interface sr_latch_driver_if;
    logic req_valid;
    logic req_op;
    logic req_ready;

    modport master (output req_valid, output req_op, input req_ready);
    modport slave  (input req_valid, input req_op, output req_ready);
endinterface

// File: rtl/sr_latch_driver.sv
// Sequences non-overlapping S/R/EN pulses into a gated SR latch and
// verifies the latch state through a synchronized Q readback.
`timescale 1ns/1ps
module sr_latch_driver #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_driver_if.slave   req,
    output logic               s_out,
    output logic               r_out,
    output logic               en_out,
    input  logic               q_fb,
    output logic               done,
    output logic               err,
    output logic [7:0]         err_cnt
);
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] CHECK_LD = 8'd1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       op_reg, op_next;
    logic [1:0] sync_reg;
    logic       q_sync;
    logic       check_end;
    logic       drive_next;
    logic       s_next, r_next, en_next, ready_next;
    logic       done_next, err_next;
    logic [7:0] err_cnt_next;

    assign q_sync = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        check_end  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req.req_valid && req.req_ready) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LD;
                    op_next    = req.req_op;
                end
            end
            SETUP: begin
                if (cnt_reg == 8'd0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            PULSE: begin
                if (cnt_reg == 8'd0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_reg == 8'd0) begin
                    state_next = CHECK;
                    cnt_next   = CHECK_LD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            CHECK: begin
                if (cnt_reg == 8'd0) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                    check_end  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase

        // Outputs are decoded from the next state so every output is a flop.
        drive_next   = (state_next == SETUP) || (state_next == PULSE) || (state_next == HOLD);
        s_next       = drive_next & op_next;
        r_next       = drive_next & ~op_next;
        en_next      = (state_next == PULSE);
        ready_next   = (state_next == IDLE);
        done_next    = check_end & (q_sync == op_reg);
        err_next     = check_end & (q_sync != op_reg);
        err_cnt_next = (err_next && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 8'd0;
            op_reg        <= 1'b0;
            sync_reg      <= 2'b00;
            s_out         <= 1'b0;
            r_out         <= 1'b0;
            en_out        <= 1'b0;
            req.req_ready <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            err_cnt       <= 8'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            sync_reg      <= {sync_reg[0], q_fb};
            s_out         <= s_next;
            r_out         <= r_next;
            en_out        <= en_next;
            req.req_ready <= ready_next;
            done          <= done_next;
            err           <= err_next;
            err_cnt       <= err_cnt_next;
        end
    end
endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: default-timing and all-ones-timing instances
// driven by random op streams against a cycle-offset waveform model.
`timescale 1ns/1ps
module tb_sr_latch_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rv = 2'b00;
    logic [1:0] rop = 2'b00;
    logic [1:0] stuck = 2'b00;
    logic [1:0] stuck_val = 2'b00;
    logic [1:0] q_lat = 2'b00;
    logic       qfb0, qfb1;
    logic       s_o [2];
    logic       r_o [2];
    logic       en_o [2];
    logic       rdy [2];
    logic       dn [2];
    logic       er [2];
    logic [7:0] ec [2];
    logic       prev_en [2];
    logic       prev_s [2];
    logic       prev_r [2];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ec [2];

    sr_latch_driver_if if0 ();
    sr_latch_driver_if if1 ();
    assign if0.req_valid = rv[0];
    assign if0.req_op    = rop[0];
    assign rdy[0]        = if0.req_ready;
    assign if1.req_valid = rv[1];
    assign if1.req_op    = rop[1];
    assign rdy[1]        = if1.req_ready;

    assign qfb0 = stuck[0] ? stuck_val[0] : q_lat[0];
    assign qfb1 = stuck[1] ? stuck_val[1] : q_lat[1];

    sr_latch_driver #(.SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(if0.slave),
        .s_out(s_o[0]), .r_out(r_o[0]), .en_out(en_o[0]), .q_fb(qfb0),
        .done(dn[0]), .err(er[0]), .err_cnt(ec[0])
    );

    sr_latch_driver #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(if1.slave),
        .s_out(s_o[1]), .r_out(r_o[1]), .en_out(en_o[1]), .q_fb(qfb1),
        .done(dn[1]), .err(er[1]), .err_cnt(ec[1])
    );

    // Behavioural gated SR latch; keeps its state when EN is low (also through reset).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_o[i]) begin
                if (s_o[i])      q_lat[i] <= 1'b1;
                else if (r_o[i]) q_lat[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants checked on every falling edge while out of reset.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                chk("inv_s_and_r", {31'd0, s_o[i] & r_o[i]}, 0);
                chk("inv_done_and_err", {31'd0, dn[i] & er[i]}, 0);
                if (en_o[i]) chk("inv_en_onehot", {31'd0, s_o[i] ^ r_o[i]}, 1);
                if (en_o[i] && prev_en[i]) begin
                    chk("inv_s_stable", {31'd0, s_o[i]}, {31'd0, prev_s[i]});
                    chk("inv_r_stable", {31'd0, r_o[i]}, {31'd0, prev_r[i]});
                end
            end
            prev_en[i] <= rst_n & en_o[i];
            prev_s[i]  <= s_o[i];
            prev_r[i]  <= r_o[i];
        end
    end

    // One operation on DUT d; expected waveform comes from cycle offsets after the handshake.
    task automatic run_op(input int d, input bit op, input bit keep);
        int  sc, pc, hc, to;
        bit  exp_q, in_win, in_pulse;
        sc = (d == 0) ? 2 : 1;
        pc = (d == 0) ? 4 : 1;
        hc = (d == 0) ? 2 : 1;
        to = 0;
        while (!rdy[d] && to < 100) begin
            tick();
            to++;
        end
        chk("ready_wait", {31'd0, rdy[d]}, 1);
        rv[d]  = 1'b1;
        rop[d] = op;
        exp_q  = stuck[d] ? stuck_val[d] : op;
        tick();
        if (!keep) rv[d] = 1'b0;
        for (int k = 1; k <= sc + pc + hc + 2; k++) begin
            in_win   = (k <= sc + pc + hc);
            in_pulse = (k > sc) && (k <= sc + pc);
            chk("s_out", {31'd0, s_o[d]}, {31'd0, in_win & op});
            chk("r_out", {31'd0, r_o[d]}, {31'd0, in_win & ~op});
            chk("en_out", {31'd0, en_o[d]}, {31'd0, in_pulse});
            chk("busy_ready", {31'd0, rdy[d]}, 0);
            chk("early_done", {31'd0, dn[d] | er[d]}, 0);
            tick();
        end
        if (exp_q != op && exp_ec[d] < 255) exp_ec[d]++;
        chk("done", {31'd0, dn[d]}, {31'd0, exp_q == op});
        chk("err", {31'd0, er[d]}, {31'd0, exp_q != op});
        chk("end_ready", {31'd0, rdy[d]}, 1);
        chk("err_cnt", {24'd0, ec[d]}, exp_ec[d]);
    endtask

    initial begin
        exp_ec[0] = 0;
        exp_ec[1] = 0;

        // Reset with a pending request
        rv[0] = 1'b1;
        rop[0] = 1'b1;
        tick();
        tick();
        chk("rst_s_out", {31'd0, s_o[0]}, 0);
        chk("rst_r_out", {31'd0, r_o[0]}, 0);
        chk("rst_en_out", {31'd0, en_o[0]}, 0);
        chk("rst_ready", {31'd0, rdy[0]}, 1);
        chk("rst_done_err", {31'd0, dn[0] | er[0]}, 0);
        chk("rst_err_cnt", {24'd0, ec[0]}, 0);
        rst_n = 1'b1;

        // Set with latch following
        run_op(0, 1'b1, 1'b0);

        // Reset op against a latch stuck at 1
        stuck[0] = 1'b1;
        stuck_val[0] = 1'b1;
        run_op(0, 1'b0, 1'b0);
        stuck[0] = 1'b0;

        // Back-to-back with req_valid held high
        run_op(0, 1'b1, 1'b1);
        run_op(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_dup_s", {31'd0, s_o[0] | r_o[0]}, 0);
            chk("no_dup_ready", {31'd0, rdy[0]}, 1);
        end

        // Random op stream on the default-timing instance
        for (int i = 0; i < 20; i++) begin
            stuck[0] = ($urandom_range(0, 3) == 0);
            stuck_val[0] = 1'($urandom_range(0, 1));
            run_op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stuck[0] = 1'b0;
        rv[0] = 1'b0;
        tick();

        // Reset in the middle of PULSE
        rv[0] = 1'b1;
        rop[0] = 1'b1;
        tick();
        rv[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_en", {31'd0, en_o[0]}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_en", {31'd0, en_o[0]}, 0);
        chk("async_s", {31'd0, s_o[0]}, 0);
        chk("async_r", {31'd0, r_o[0]}, 0);
        chk("async_ready", {31'd0, rdy[0]}, 1);
        tick();
        tick();
        rst_n = 1'b1;
        exp_ec[0] = 0;
        exp_ec[1] = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_done_err", {31'd0, dn[0] | er[0]}, 0);
            chk("post_rst_ready", {31'd0, rdy[0]}, 1);
        end
        chk("post_rst_err_cnt", {24'd0, ec[0]}, 0);

        // Minimum-timing instance: random ops, then saturation
        for (int i = 0; i < 20; i++) begin
            stuck[1] = ($urandom_range(0, 4) == 0);
            stuck_val[1] = 1'($urandom_range(0, 1));
            run_op(1, 1'($urandom_range(0, 1)), 1'b0);
        end
        stuck[1] = 1'b1;
        for (int i = 0; i < 260; i++) begin
            bit op;
            op = 1'($urandom_range(0, 1));
            stuck_val[1] = ~op;
            run_op(1, op, 1'b0);
        end
        chk("sat_err_cnt", {24'd0, ec[1]}, 255);
        stuck[1] = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
